regfile_2r1w_init: RTL
======================

// Module: regfile_2r1w_init
// PURPOSE
//  Parametrised register file for the RISC-V core: 2 synchronous read ports, 1 write port.
//  Adds write-to-read forwarding, an optional hardwired-zero entry 0, and a sequential
//  init/clear engine, so the storage array itself needs no asynchronous reset.
//  Sits between decode (read addresses) and writeback (write port) of the pipeline.
// PARAMETERS
//  DATA_W    32          data width in bits
//  DEPTH     32          number of entries, >= 2, need not be a power of 2
//  ZERO_REG  1           1: entry 0 reads 0 and ignores writes (RISC-V x0); 0: entry 0 is ordinary
//  INIT_VAL  '0          value written to every entry during init/clear (DATA_W bits)
//  AW        $clog2(DEPTH)  address width (derived, not to be overridden)
// PORTS
//  clk      in   1       clock, rising edge
//  rstn     in   1       reset, asynchronous, active-low
//  clr      in   1       synchronous request to re-initialise all entries
//  ready    out  1       1 = RUN state, port accesses honoured
//  we       in   1       write enable
//  waddr    in   AW      write address
//  wdata    in   DATA_W  write data
//  re0      in   1       read enable, port 0
//  raddr0   in   AW      read address, port 0
//  rdata0   out  DATA_W  read data, port 0 (registered)
//  re1      in   1       read enable, port 1
//  raddr1   in   AW      read address, port 1
//  rdata1   out  DATA_W  read data, port 1 (registered)
// BEHAVIOUR
//  Reset (rstn=0, async): state=INIT, init counter cnt=0, ready=0, rdata0=rdata1=0.
//    Array contents are not reset directly.
//  FSM INIT: each cycle write INIT_VAL to entry cnt, cnt++.
//    After the cycle with cnt==DEPTH-1: go to RUN; ready=1 from the next edge.
//    ready therefore rises DEPTH cycles after rstn deasserts.
//  FSM RUN: normal operation. clr=1 -> INIT with cnt=0; ready=0 from the next edge.
//    clr=1 while already in INIT -> cnt restarts at 0.
//  In INIT: we is ignored. A read with reX=1 loads rdataX<=0.
//  Write (RUN): we=1 writes wdata to waddr at the edge.
//    Ignored if waddr>=DEPTH, or if ZERO_REG=1 and waddr==0.
//  Read (RUN): reX=1 -> rdataX <= entry[raddrX] at the edge, 1-cycle latency.
//    reX=0 -> rdataX holds its previous value.
//    Reads are independent of we; both ports may read the same address.
//  Forwarding: reX=1 & we=1 & raddrX==waddr & write not ignored -> rdataX<=wdata (write-first).
//  raddrX>=DEPTH -> rdataX<=0. ZERO_REG=1 & raddrX==0 -> rdataX<=0, even if forwarding matches.
//  Reset mid-operation: all in-flight state is discarded and init restarts from 0.
// TESTING
//  1 Reset, DEPTH=32: ready=0 for exactly 32 cycles after rstn rises, then 1;
//    every address then reads INIT_VAL.
//  2 Write 0xDEADBEEF to addr 5, next cycle read on both ports -> rdata0=rdata1=0xDEADBEEF
//    one cycle after the read.
//  3 Same cycle: we=1, waddr=7, wdata=0x12345678, re0=1, raddr0=7 -> rdata0=0x12345678
//    next cycle; entry 7 keeps that value.
//  4 ZERO_REG=1: write 0xFFFFFFFF to addr 0 -> reads of addr 0 return 0, including the
//    same-cycle forwarding case.
//  5 Write 0xA5 to addr 3, pulse clr: ready=0 for 32 cycles, then addr 3 reads INIT_VAL;
//    a we=1 during INIT has no effect.
//  6 DEPTH=20: write to addr 25 is ignored; read of addr 25 -> 0;
//    re0=0 holds rdata0 across address changes.

Source files
------------

// File: rtl/regfile_2r1w_init.sv
// Two-read / one-write register file with write-first forwarding, optional hardwired x0
// and a sequential init/clear engine that fills the array with INIT_VAL after reset or clr.
module regfile_2r1w_init #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 32,
  parameter bit                ZERO_REG = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  localparam int               AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  output logic              ready,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re0,
  input  logic [AW-1:0]     raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              re1,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_reg;
  logic [AW-1:0]     cnt_reg;
  logic              run;
  logic              wr_ok;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [1:0]        re_v;
  logic [AW-1:0]     raddr_v [2];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
      ready     <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          if (clr) begin
            cnt_reg <= '0;
          end else if (cnt_reg == LAST) begin
            state_reg <= ST_RUN;
            ready     <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_RUN: begin
          if (clr) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
            ready     <= 1'b0;
          end
        end
        default: state_reg <= ST_INIT;
      endcase
    end
  end

  assign run = (state_reg == ST_RUN);

  // The single array write port is shared between the init engine and the user port.
  always_comb begin
    wr_ok     = run && we && ({1'b0, waddr} < DEPTH_C) && !(ZERO_REG && (waddr == '0));
    mem_we    = !run || wr_ok;
    mem_waddr = run ? waddr : cnt_reg;
    mem_wdata = run ? wdata : INIT_VAL;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign re_v       = {re1, re0};
  assign raddr_v[0] = raddr0;
  assign raddr_v[1] = raddr1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic              addr_ok;
      logic              fwd;
      logic [DATA_W-1:0] rdata_reg;

      assign addr_ok = ({1'b0, raddr_v[gi]} < DEPTH_C) && !(ZERO_REG && (raddr_v[gi] == '0));
      assign fwd     = wr_ok && (waddr == raddr_v[gi]);

      // Out-of-range and x0 reads return zero even when a forward would match.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rdata_reg <= '0;
        end else if (re_v[gi]) begin
          if (!run || !addr_ok) begin
            rdata_reg <= '0;
          end else if (fwd) begin
            rdata_reg <= wdata;
          end else begin
            rdata_reg <= mem[raddr_v[gi]];
          end
        end
      end
    end
  endgenerate

  assign rdata0 = g_rd[0].rdata_reg;
  assign rdata1 = g_rd[1].rdata_reg;

endmodule
